// File: rtl/gestor_pkg.sv
// Shared definitions for the end-time manager: channel states and default sizing.
package gestor_pkg;

   typedef enum logic {
      LIVRE = 1'b0,
      ATIVO = 1'b1
   } estado_t;

   localparam int unsigned W_DEFAULT       = 7;
   localparam int unsigned N_DEFAULT       = 4;
   localparam int unsigned DUR_DEFAULT_VAL = 6;

   // Width of a channel index; never below one bit so a single-channel build stays legal.
   function automatic int unsigned largura_idx(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/canal_termino.sv
// One channel: LIVRE/ATIVO state, stored end time and registered expiry pulse.
module canal_termino
   import gestor_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_carregar,
   input  logic [W-1:0] i_termino_novo,
   input  logic         i_cancelar,
   input  logic [W-1:0] i_tempo,
   output logic         o_ocupado,
   output logic         o_fim,
   output logic [W-1:0] o_termino
);

   estado_t      r_estado;
   estado_t      w_prox;
   logic         r_fim;
   logic         w_fim_prox;
   logic [W-1:0] r_termino;

   // State and expiry pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= LIVRE;
         r_fim    <= 1'b0;
      end else begin
         r_estado <= w_prox;
         r_fim    <= w_fim_prox;
      end
   end

   // End time is captured only on an accepted start; it is kept while idle for readback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_termino <= '0;
      end else if (i_carregar && (r_estado == LIVRE)) begin
         r_termino <= i_termino_novo;
      end
   end

   // Next state: cancel wins over expiry, and expiry is an equality match so wrap is harmless.
   always_comb begin
      w_prox     = r_estado;
      w_fim_prox = 1'b0;
      unique case (r_estado)
         LIVRE: begin
            if (i_carregar) begin
               w_prox = ATIVO;
            end
         end
         ATIVO: begin
            if (i_cancelar) begin
               w_prox = LIVRE;
            end else if (r_termino == i_tempo) begin
               w_prox     = LIVRE;
               w_fim_prox = 1'b1;
            end
         end
         default: w_prox = LIVRE;
      endcase
   end

   assign o_ocupado = (r_estado == ATIVO);
   assign o_fim     = r_fim;
   assign o_termino = r_termino;

endmodule

// File: rtl/gestor_termino.sv
// Multi-channel end-time manager: shared time base, start decode and end-time readback.
module gestor_termino
   import gestor_pkg::*;
#(
   parameter int unsigned W           = W_DEFAULT,
   parameter int unsigned N           = N_DEFAULT,
   parameter int unsigned DUR_DEFAULT = DUR_DEFAULT_VAL
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        tick,
   input  logic                        arranque,
   input  logic [largura_idx(N)-1:0]   canal,
   input  logic [W-1:0]                duracao,
   input  logic [N-1:0]                cancelar,
   input  logic [largura_idx(N)-1:0]   sel,
   output logic [W-1:0]                tempo,
   output logic [N-1:0]                ocupado,
   output logic [N-1:0]                fim,
   output logic                        aceite,
   output logic                        erro,
   output logic [W-1:0]                termino_sel
);

   localparam int unsigned CW = largura_idx(N);

   logic [W-1:0] r_tempo;
   logic [W-1:0] w_dur;
   logic [W-1:0] w_termino_novo;
   logic         w_canal_valido;
   logic         w_livre;
   logic         w_cancel_canal;
   logic [N-1:0] w_ocupado;
   logic [N-1:0] w_fim;
   logic [N-1:0] w_carregar;
   logic [W-1:0] w_termino [N];

   // Free-running time base, advancing only on tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tempo <= '0;
      end else if (tick) begin
         r_tempo <= r_tempo + 1'b1;
      end
   end

   // Start decode: accept only an in-range, idle, non-cancelled channel; end time uses pre-edge tempo.
   always_comb begin
      w_canal_valido = (32'(canal) < N);
      w_livre        = 1'b0;
      w_cancel_canal = 1'b0;
      if (w_canal_valido) begin
         w_livre        = !w_ocupado[canal];
         w_cancel_canal = cancelar[canal];
      end
      aceite         = arranque && w_canal_valido && w_livre && !w_cancel_canal;
      erro           = arranque && !aceite;
      w_dur          = (duracao == '0) ? W'(DUR_DEFAULT) : duracao;
      w_termino_novo = r_tempo + w_dur;
   end

   for (genvar g = 0; g < N; g++) begin : g_canal
      assign w_carregar[g] = aceite && (canal == CW'(g));

      canal_termino #(
         .W (W)
      ) u_canal (
         .clk            (clk),
         .rst_n          (rst_n),
         .i_carregar     (w_carregar[g]),
         .i_termino_novo (w_termino_novo),
         .i_cancelar     (cancelar[g]),
         .i_tempo        (r_tempo),
         .o_ocupado      (w_ocupado[g]),
         .o_fim          (w_fim[g]),
         .o_termino      (w_termino[g])
      );
   end

   // Readback mux of the selected channel's stored end time.
   always_comb begin
      termino_sel = '0;
      if (32'(sel) < N) begin
         termino_sel = w_termino[sel];
      end
   end

   assign tempo   = r_tempo;
   assign ocupado = w_ocupado;
   assign fim     = w_fim;

endmodule

// File: tb/tb_gestor_termino.sv
// Bench for gestor_termino: remaining-ticks reference model, per-cycle compare, directed and random stimulus.
module tb_gestor_termino;

   localparam int W       = 7;
   localparam int N       = 4;
   localparam int DUR_DEF = 6;
   localparam int MODV    = 128;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         tick     = 1'b0;
   logic         arranque = 1'b0;
   logic [1:0]   canal    = '0;
   logic [W-1:0] duracao  = '0;
   logic [N-1:0] cancelar = '0;
   logic [1:0]   sel      = '0;
   logic [W-1:0] tempo;
   logic [N-1:0] ocupado;
   logic [N-1:0] fim;
   logic         aceite;
   logic         erro;
   logic [W-1:0] termino_sel;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: each active channel counts remaining ticks until tempo meets its end time.
   int           m_tempo = 0;
   logic [N-1:0] m_act   = '0;
   logic [N-1:0] m_fim   = '0;
   int           m_rem  [N];
   int           m_term [N];

   always #5 clk = ~clk;

   gestor_termino #(
      .W           (W),
      .N           (N),
      .DUR_DEFAULT (DUR_DEF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .arranque    (arranque),
      .canal       (canal),
      .duracao     (duracao),
      .cancelar    (cancelar),
      .sel         (sel),
      .tempo       (tempo),
      .ocupado     (ocupado),
      .fim         (fim),
      .aceite      (aceite),
      .erro        (erro),
      .termino_sel (termino_sel)
   );

   task automatic chk(input string nome, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
      end
   endtask

   function automatic int dur_of(input int d);
      return (d == 0) ? DUR_DEF : d;
   endfunction

   function automatic logic exp_aceite();
      return arranque && !m_act[canal] && !cancelar[canal];
   endfunction

   // Model update on each clock edge, cleared asynchronously by reset.
   always @(posedge clk or negedge rst_n) begin : modelo
      logic ac;
      int   d;
      if (!rst_n) begin
         m_tempo = 0;
         m_act   = '0;
         m_fim   = '0;
         for (int i = 0; i < N; i++) begin
            m_rem[i]  = 0;
            m_term[i] = 0;
         end
      end else begin
         ac = exp_aceite();
         for (int i = 0; i < N; i++) begin
            m_fim[i] = 1'b0;
            if (m_act[i]) begin
               if (cancelar[i]) begin
                  m_act[i] = 1'b0;
               end else if (m_rem[i] == 0) begin
                  m_act[i] = 1'b0;
                  m_fim[i] = 1'b1;
               end else if (tick) begin
                  m_rem[i] = m_rem[i] - 1;
               end
            end else if (ac && (int'(canal) == i)) begin
               d         = dur_of(int'(duracao));
               m_act[i]  = 1'b1;
               m_term[i] = (m_tempo + d) % MODV;
               m_rem[i]  = d - (tick ? 1 : 0);
            end
         end
         m_tempo = (m_tempo + (tick ? 1 : 0)) % MODV;
      end
   end

   // Every-cycle compare of all outputs against the model, away from the active edge.
   always @(negedge clk) begin
      logic ea;
      ea = exp_aceite();
      chk("aceite",      int'(aceite),      int'(ea));
      chk("erro",        int'(erro),        int'(arranque && !ea));
      chk("tempo",       int'(tempo),       m_tempo);
      chk("ocupado",     int'(ocupado),     int'(m_act));
      chk("fim",         int'(fim),         int'(m_fim));
      chk("termino_sel", int'(termino_sel), m_term[sel]);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      arranque = 1'b0;
      cancelar = '0;
   endtask

   task automatic start(input int c, input int d);
      arranque = 1'b1;
      canal    = 2'(c);
      duracao  = 7'(d);
   endtask

   initial begin
      int r;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rst_tempo",   int'(tempo),   0);
      chk("rst_ocupado", int'(ocupado), 0);
      chk("rst_fim",     int'(fim),     0);

      // Default duration from tempo 0.
      tick = 1'b1;
      sel  = 2'd0;
      start(0, 0);
      #1;
      chk("d34_aceite", int'(aceite), 1);
      cyc();
      idle();
      #1;
      chk("d34_termino", int'(termino_sel), 6);
      chk("d34_ocup",    int'(ocupado),     1);
      repeat (5) cyc();
      chk("d34_tempo6",  int'(tempo),   6);
      chk("d34_nofim",   int'(fim),     0);
      cyc();
      chk("d34_fim",     int'(fim),     1);
      chk("d34_livre",   int'(ocupado), 0);
      cyc();
      chk("d34_fimoff",  int'(fim),     0);

      // Wrap-around end time.
      for (int k = 0; k < 200 && tempo != 7'd125; k++) cyc();
      chk("d35_sync", int'(tempo), 125);
      sel = 2'd1;
      start(1, 5);
      cyc();
      idle();
      #1;
      chk("d35_termino", int'(termino_sel), 2);
      repeat (4) cyc();
      chk("d35_tempo2", int'(tempo), 2);
      chk("d35_nofim",  int'(fim),   0);
      cyc();
      chk("d35_fim",    int'(fim),   2);

      // Rejected starts: busy channel and cancel on the addressed channel.
      sel = 2'd2;
      start(2, 10);
      cyc();
      start(2, 3);
      #1;
      chk("d36_busy_aceite", int'(aceite), 0);
      chk("d36_busy_erro",   int'(erro),   1);
      cyc();
      idle();
      #1;
      chk("d36_term_kept", int'(termino_sel), 13);
      chk("d36_ocup",      int'(ocupado),     4);
      cancelar = 4'b0100;
      cyc();
      idle();
      #1;
      chk("d36_cancel_ocup", int'(ocupado), 0);
      chk("d36_cancel_fim",  int'(fim),     0);
      start(2, 1);
      cancelar = 4'b0100;
      #1;
      chk("d36_canc_aceite", int'(aceite), 0);
      chk("d36_canc_erro",   int'(erro),   1);
      cyc();
      idle();
      #1;
      chk("d36_canc_ocup", int'(ocupado),     0);
      chk("d36_canc_term", int'(termino_sel), 13);

      // Simultaneous expiry, then cancel on the expiry edge.
      start(0, 8);
      cyc();
      start(3, 7);
      cyc();
      idle();
      repeat (6) cyc();
      chk("d37_tempo", int'(tempo),   15);
      chk("d37_ocup",  int'(ocupado), 9);
      cyc();
      chk("d37_fim",   int'(fim),     9);
      chk("d37_livre", int'(ocupado), 0);
      start(0, 8);
      cyc();
      start(3, 7);
      cyc();
      idle();
      repeat (6) cyc();
      cancelar = 4'b1000;
      cyc();
      idle();
      chk("d37_fim_canc", int'(fim),     1);
      chk("d37_livre2",   int'(ocupado), 0);

      // Frozen time base.
      start(1, 4);
      cyc();
      idle();
      tick = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         chk("d38_frozen", int'(tempo), 26);
         chk("d38_nofim",  int'(fim),   0);
      end
      tick = 1'b1;
      repeat (3) cyc();
      chk("d38_tempo",  int'(tempo),   29);
      chk("d38_ocup",   int'(ocupado), 2);
      chk("d38_prefim", int'(fim),     0);
      cyc();
      chk("d38_fim",    int'(fim),     2);

      // Asynchronous reset with every channel active.
      for (int c = 0; c < N; c++) begin
         start(c, 100);
         cyc();
      end
      idle();
      #1;
      chk("d39_all_busy", int'(ocupado), 15);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("d39_tempo",   int'(tempo),       0);
      chk("d39_ocup",    int'(ocupado),     0);
      chk("d39_fim",     int'(fim),         0);
      chk("d39_termino", int'(termino_sel), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Random traffic.
      for (int k = 0; k < 4000; k++) begin
         tick     = ($urandom_range(0, 99) < 85);
         arranque = ($urandom_range(0, 9) < 3);
         canal    = 2'($urandom_range(0, 3));
         sel      = 2'($urandom_range(0, 3));
         r        = int'($urandom_range(0, 9));
         if (r < 2)      duracao = '0;
         else if (r < 7) duracao = 7'($urandom_range(1, 12));
         else            duracao = 7'($urandom_range(0, 127));
         for (int b = 0; b < N; b++) cancelar[b] = ($urandom_range(0, 31) == 0);
         cyc();
      end
      idle();
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
